// File: rtl/mm_pkg.sv
// Register map, CTRL/STATUS bit positions and sequencer states shared by
// mm_sequencer and anything that decodes its register space.
package mm_pkg;

    localparam int A_BASE     = 0;
    localparam int B_BASE     = 9;
    localparam int C_BASE     = 18;
    localparam int CTRL_ADR   = 27;
    localparam int STATUS_ADR = 28;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TOUT    = 2;
    localparam int STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_TOUT = 2'd3
    } state_t;

endpackage

// File: rtl/mm_sequencer.sv
// Wishbone register front end that sequences a 3x3 matrix_mult run with watchdog and IRQ.
// One-cycle registered ack/err per request; no stalls, illegal accesses (incl. writes while busy) get err.
module mm_sequencer
    import mm_pkg::*;
#(
    parameter int INT_WIDTH = 8,
    parameter int MAT_SIZE  = 9,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cyc,
    input  logic                          stb,
    input  logic                          we,
    input  logic [3:0]                    wb_sel,
    input  logic [31:0]                   adr,
    input  logic [31:0]                   dat_mosi,
    output logic [31:0]                   dat_miso,
    output logic                          ack,
    output logic                          err,
    output logic                          irq,
    output logic                          mm_enable,
    output logic [MAT_SIZE*INT_WIDTH-1:0] mm_a,
    output logic [MAT_SIZE*INT_WIDTH-1:0] mm_b,
    input  logic [MAT_SIZE*INT_WIDTH-1:0] mm_c,
    input  logic                          mm_done
);

    localparam int         MW       = MAT_SIZE * INT_WIDTH;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [MW-1:0]   c_q;
    logic [7:0]      run_cnt_q;
    logic            irq_en_q;
    logic            req, busy;
    logic            in_a, in_b, in_c;
    logic [3:0]      el_idx;
    logic            rsp_ack, rsp_err;
    logic            wr_a, wr_b, wr_ctrl, go_start, go_clear;
    logic [31:0]     rd_dat;
    logic            unused_bits;

    assign req       = cyc && stb && !ack && !err;
    assign busy      = (state_q == S_RUN);
    assign mm_enable = busy;
    assign in_a      = adr < 32'(B_BASE);
    assign in_b      = !in_a && (adr < 32'(C_BASE));
    assign in_c      = !in_a && !in_b && (adr < 32'(CTRL_ADR));
    assign unused_bits = ^{wb_sel[3:1], dat_mosi[31:INT_WIDTH]};

    always_comb begin
        state_d  = state_q;
        rsp_ack  = 1'b0;
        rsp_err  = 1'b0;
        rd_dat   = '0;
        wr_a     = 1'b0;
        wr_b     = 1'b0;
        wr_ctrl  = 1'b0;
        go_start = 1'b0;
        go_clear = 1'b0;
        el_idx   = 4'(adr[4:0] - 5'(A_BASE));
        if (in_b) el_idx = 4'(adr[4:0] - 5'(B_BASE));
        if (in_c) el_idx = 4'(adr[4:0] - 5'(C_BASE));

        if (req) begin
            if (in_a || in_b) begin
                // operands must stay stable for the datapath while a run is in flight
                if (!we) begin
                    rsp_ack = 1'b1;
                    rd_dat  = in_a ? 32'(mm_a[int'(el_idx)*INT_WIDTH +: INT_WIDTH])
                                   : 32'(mm_b[int'(el_idx)*INT_WIDTH +: INT_WIDTH]);
                end else if (!wb_sel[0] || busy) begin
                    rsp_err = 1'b1;
                end else begin
                    rsp_ack = 1'b1;
                    wr_a    = in_a;
                    wr_b    = in_b;
                end
            end else if (in_c) begin
                if (we) begin
                    rsp_err = 1'b1;
                end else begin
                    rsp_ack = 1'b1;
                    rd_dat  = 32'(c_q[int'(el_idx)*INT_WIDTH +: INT_WIDTH]);
                end
            end else if (adr == 32'(CTRL_ADR)) begin
                if (!we) begin
                    rsp_ack = 1'b1;
                    rd_dat[CTRL_IRQ_EN] = irq_en_q;
                end else if (!wb_sel[0] || (busy && dat_mosi[CTRL_START])) begin
                    rsp_err = 1'b1;
                end else begin
                    rsp_ack  = 1'b1;
                    wr_ctrl  = 1'b1;
                    go_start = dat_mosi[CTRL_START];
                    go_clear = dat_mosi[CTRL_CLEAR];
                end
            end else if (adr == 32'(STATUS_ADR) && !we) begin
                rsp_ack = 1'b1;
                rd_dat[STAT_BUSY] = busy;
                rd_dat[STAT_DONE] = (state_q == S_DONE);
                rd_dat[STAT_TOUT] = (state_q == S_TOUT);
                rd_dat[STAT_CNT_LSB +: 8] = run_cnt_q;
            end else begin
                rsp_err = 1'b1;
            end
        end

        // done wins over the watchdog on the same cycle; START wins over CLEAR
        case (state_q)
            S_RUN: begin
                if (mm_done)                     state_d = S_DONE;
                else if (run_cnt_q == CNT_LAST)  state_d = S_TOUT;
            end
            S_IDLE: begin
                if (go_start) state_d = S_RUN;
            end
            default: begin
                if (go_start)      state_d = S_RUN;
                else if (go_clear) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ack       <= 1'b0;
            err       <= 1'b0;
            dat_miso  <= '0;
            irq       <= 1'b0;
            irq_en_q  <= 1'b0;
            run_cnt_q <= '0;
            mm_a      <= '0;
            mm_b      <= '0;
            c_q       <= '0;
        end else begin
            state_q  <= state_d;
            ack      <= rsp_ack;
            err      <= rsp_err;
            dat_miso <= rd_dat;
            if (wr_a) mm_a[int'(el_idx)*INT_WIDTH +: INT_WIDTH] <= dat_mosi[INT_WIDTH-1:0];
            if (wr_b) mm_b[int'(el_idx)*INT_WIDTH +: INT_WIDTH] <= dat_mosi[INT_WIDTH-1:0];
            if (wr_ctrl) irq_en_q <= dat_mosi[CTRL_IRQ_EN];
            if (go_start)
                run_cnt_q <= '0;
            else if (busy && run_cnt_q != 8'hFF)
                run_cnt_q <= run_cnt_q + 8'd1;
            if (busy && mm_done) c_q <= mm_c;
            if (busy && state_d != S_RUN)
                irq <= irq_en_q;
            else if (state_d == S_RUN || state_d == S_IDLE)
                irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed bench for mm_sequencer: Wishbone host tasks plus a small matrix_mult model
// whose done latency is programmable per run (0 = never completes).
module tb_mm_sequencer;

    localparam int IW = 8;
    localparam int MS = 9;
    localparam int MW = IW * MS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]    wb_sel = 4'h0;
    logic [31:0]   adr = '0, dat_mosi = '0;
    logic [31:0]   dat_miso;
    logic          ack, err, irq, mm_enable;
    logic [MW-1:0] mm_a, mm_b, mm_c;
    logic          mm_done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_delay = 0;
    int en_cnt = 0;
    int low_run = 0;
    int last_low = 0;

    mm_sequencer #(.INT_WIDTH(IW), .MAT_SIZE(MS), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we), .wb_sel(wb_sel),
        .adr(adr), .dat_mosi(dat_mosi), .dat_miso(dat_miso), .ack(ack), .err(err),
        .irq(irq), .mm_enable(mm_enable), .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c),
        .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] c;
        logic [IW-1:0] acc;
        c = '0;
        for (int r = 0; r < 3; r++) begin
            for (int col = 0; col < 3; col++) begin
                acc = '0;
                for (int k = 0; k < 3; k++)
                    acc = acc + IW'(a[(r*3+k)*IW +: IW] * b[(k*3+col)*IW +: IW]);
                c[(r*3+col)*IW +: IW] = acc;
            end
        end
        return c;
    endfunction

    assign mm_c    = matmul(mm_a, mm_b);
    assign mm_done = mm_enable && (done_delay != 0) && (en_cnt == done_delay);

    // en_cnt == k at the k-th rising edge after enable rose; low_run measures enable-low gaps
    always @(negedge clk) begin
        if (mm_enable) begin
            en_cnt <= en_cnt + 1;
            if (low_run != 0) last_low <= low_run;
            low_run <= 0;
        end else begin
            en_cnt  <= 0;
            low_run <= low_run + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rd, output logic [1:0] rsp);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_mosi = d; wb_sel = sel;
        rsp = 2'b00;
        rd  = '0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk);
            #1;
            if (ack || err) break;
        end
        rsp = {ack, err};
        rd  = dat_miso;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr_ack(input string tag, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic [1:0]  rsp;
        wb_xfer(1'b1, a, d, 4'hF, rd, rsp);
        check({tag, "_ack"}, 32'(rsp), 32'h2);
    endtask

    task automatic wr_err(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] sel);
        logic [31:0] rd;
        logic [1:0]  rsp;
        wb_xfer(1'b1, a, d, sel, rd, rsp);
        check({tag, "_err"}, 32'(rsp), 32'h1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic [1:0]  rsp;
        wb_xfer(1'b0, a, '0, 4'hF, rd, rsp);
        check({tag, "_ack"}, 32'(rsp), 32'h2);
        check(tag, rd, exp);
    endtask

    task automatic rd_err(input string tag, input logic [31:0] a);
        logic [31:0] rd;
        logic [1:0]  rsp;
        wb_xfer(1'b0, a, '0, 4'hF, rd, rsp);
        check({tag, "_err"}, 32'(rsp), 32'h1);
    endtask

    // cycles from the return of the START write until mm_enable is seen low
    task automatic wait_fall(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!mm_enable) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_en", 32'(mm_enable), 32'h0);
        check("rst_miso", dat_miso, 32'h0);

        // reset in the middle of a run
        wr_ack("a0", 0, 32'h5);
        wr_ack("b1", 10, 32'h7);
        check("mm_a_ld", mm_a[31:0], 32'h0000_0005);
        check("mm_b_ld", mm_b[31:0], 32'h0000_0700);
        done_delay = 0;
        wr_ack("start0", 27, 32'h1);
        check("run_en", 32'(mm_enable), 32'h1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_en", 32'(mm_enable), 32'h0);
        check("mrst_a", mm_a[31:0], 32'h0);
        check("mrst_b", mm_b[31:0], 32'h0);
        check("mrst_irq", 32'(irq), 32'h0);
        check("mrst_ack", 32'({ack, err}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("mrst_status", 28, 32'h0);
        rd_chk("mrst_ctrl", 27, 32'h0);

        // identity x B, done after 4 cycles, IRQ disabled
        wr_ack("a_id0", 0, 32'h1);
        wr_ack("a_id4", 4, 32'h1);
        wr_ack("a_id8", 8, 32'h1);
        for (int i = 0; i < 9; i++) wr_ack($sformatf("b%0d", i), 32'(9 + i), 32'(i + 1));
        rd_chk("rd_b4", 13, 32'h5);
        rd_chk("rd_a4", 4, 32'h1);
        done_delay = 4;
        wr_ack("start1", 27, 32'h1);
        wait_fall(n);
        check("done_cycles", 32'(n), 32'd4);
        check("done_irq", 32'(irq), 32'h0);
        rd_chk("done_status", 28, 32'h0402);
        for (int i = 0; i < 9; i++) rd_chk($sformatf("c%0d", i), 32'(18 + i), 32'(i + 1));

        // watchdog expiry with IRQ enabled, then CLEAR
        done_delay = 0;
        wr_ack("irq_en", 27, 32'h2);
        rd_chk("rd_ctrl", 27, 32'h2);
        wr_ack("start2", 27, 32'h3);
        wait_fall(n);
        check("tout_cycles", 32'(n), 32'd8);
        check("tout_irq", 32'(irq), 32'h1);
        rd_chk("tout_status", 28, 32'h0804);
        wr_ack("clear", 27, 32'h6);
        check("clr_irq", 32'(irq), 32'h0);
        rd_chk("clr_status", 28, 32'h0800);

        // accesses while running
        wr_ack("start3", 27, 32'h3);
        wr_err("run_wr_a", 0, 32'h9, 4'hF);
        wr_err("run_start", 27, 32'h1, 4'hF);
        check("run_mm_a", mm_a[31:0], 32'h0000_0001);
        rd_chk("run_rd_c0", 18, 32'h1);
        check("run_still_en", 32'(mm_enable), 32'h1);
        wait_fall(n);
        rd_chk("run_tout_status", 28, 32'h0804);

        // done on the watchdog cycle wins; illegal addresses and byte selects
        wr_ack("b0_new", 9, 32'h10);
        done_delay = 8;
        wr_ack("start4", 27, 32'h3);
        wait_fall(n);
        check("edge_cycles", 32'(n), 32'd8);
        rd_chk("edge_status", 28, 32'h0802);
        check("edge_irq", 32'(irq), 32'h1);
        rd_chk("edge_c0", 18, 32'h10);
        wr_err("adr29_wr", 29, 32'h1, 4'hF);
        rd_err("adr29_rd", 29);
        wr_err("sel_a1", 1, 32'h33, 4'b0010);
        check("sel_mm_a", mm_a[31:0], 32'h0000_0001);
        wr_err("wr_c", 18, 32'h1, 4'hF);

        // START+CLEAR from DONE restarts immediately after a one-cycle enable gap
        done_delay = 1;
        wr_ack("start5", 27, 32'h7);
        @(posedge clk);
        #1;
        check("quick_en", 32'(mm_enable), 32'h0);
        check("quick_irq", 32'(irq), 32'h1);
        done_delay = 3;
        wr_ack("start_clr", 27, 32'h7);
        check("restart_irq", 32'(irq), 32'h0);
        wait_fall(n);
        check("restart_cycles", 32'(n), 32'd3);
        check("gap_cycles", 32'(last_low), 32'd1);
        rd_chk("restart_status", 28, 32'h0302);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
